// File: rtl/carrier_wipeoff_accum_if.sv
// Sample/DDS input bundle and dumped-sum output bundle for the carrier wipe-off integrator.
// The master side drives samples and window length; the slave side returns the I/Q dumps.
interface carrier_wipeoff_accum_if #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 24,
  parameter int LEN_WIDTH = 16
);
  logic                        en;
  logic signed [IN_WIDTH-1:0]  in_i;
  logic signed [IN_WIDTH-1:0]  in_q;
  logic signed [2:0]           sin;
  logic signed [2:0]           cos;
  logic [LEN_WIDTH-1:0]        acc_len;
  logic signed [OUT_WIDTH-1:0] acc_i;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic                        valid;
  logic                        overflow;

  modport master (
    output en, in_i, in_q, sin, cos, acc_len,
    input  acc_i, acc_q, valid, overflow
  );

  modport slave (
    input  en, in_i, in_q, sin, cos, acc_len,
    output acc_i, acc_q, valid, overflow
  );
endinterface

// File: rtl/carrier_wipeoff_accum.sv
// Complex mix of samples by e^(-j*phi) from the DDS sin/cos, then integrate-and-dump over
// a programmable window. Any en drop discards the partial window to stay phase-aligned.
module carrier_wipeoff_accum #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 24,
  parameter int LEN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     syn_reset,
  carrier_wipeoff_accum_if.slave   bus
);
  localparam int PW = IN_WIDTH + 3;
  localparam int MW = IN_WIDTH + 4;

  // vld_pipe[0] = en_d1 (products valid), vld_pipe[1] = en_d2 (mixed samples valid)
  logic [1:0] vld_pipe_q, vld_pipe_d;

  logic signed [PW-1:0] p_ic_q, p_ic_d;
  logic signed [PW-1:0] p_qs_q, p_qs_d;
  logic signed [PW-1:0] p_qc_q, p_qc_d;
  logic signed [PW-1:0] p_is_q, p_is_d;

  logic signed [MW-1:0] mi_q, mi_d;
  logic signed [MW-1:0] mq_q, mq_d;

  logic signed [OUT_WIDTH-1:0] sum_i_q, sum_i_d;
  logic signed [OUT_WIDTH-1:0] sum_q_q, sum_q_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;

  logic signed [OUT_WIDTH-1:0] dump_i_q, dump_i_d;
  logic signed [OUT_WIDTH-1:0] dump_q_q, dump_q_d;
  logic                        dump_vld_q, dump_vld_d;

  logic signed [OUT_WIDTH-1:0] acc_i_q, acc_i_d;
  logic signed [OUT_WIDTH-1:0] acc_q_q, acc_q_d;
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;

  logic signed [OUT_WIDTH-1:0] ext_i, ext_q, add_i, add_q;
  logic [LEN_WIDTH-1:0]        cur_len;
  logic                        ovf_i, ovf_q_ch;

  // Stage 1: full-precision products, loaded only on valid samples
  always_comb begin
    p_ic_d = p_ic_q;
    p_qs_d = p_qs_q;
    p_qc_d = p_qc_q;
    p_is_d = p_is_q;
    if (bus.en) begin
      p_ic_d = PW'(bus.in_i) * PW'(bus.cos);
      p_qs_d = PW'(bus.in_q) * PW'(bus.sin);
      p_qc_d = PW'(bus.in_q) * PW'(bus.cos);
      p_is_d = PW'(bus.in_i) * PW'(bus.sin);
    end
  end

  // Stage 2: multiply by conjugate phasor, one extra bit keeps the sum exact
  always_comb begin
    mi_d = mi_q;
    mq_d = mq_q;
    if (vld_pipe_q[0]) begin
      mi_d = MW'(p_ic_q) + MW'(p_qs_q);
      mq_d = MW'(p_qc_q) - MW'(p_is_q);
    end
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], bus.en};
  end

  // Stage 3: integrate and dump
  always_comb begin
    ext_i   = OUT_WIDTH'(mi_q);
    ext_q   = OUT_WIDTH'(mq_q);
    add_i   = sum_i_q + ext_i;
    add_q   = sum_q_q + ext_q;
    ovf_i    = (sum_i_q[OUT_WIDTH-1] == ext_i[OUT_WIDTH-1]) &&
               (add_i[OUT_WIDTH-1]   != sum_i_q[OUT_WIDTH-1]);
    ovf_q_ch = (sum_q_q[OUT_WIDTH-1] == ext_q[OUT_WIDTH-1]) &&
               (add_q[OUT_WIDTH-1]   != sum_q_q[OUT_WIDTH-1]);
    // window length is sampled only at window start; zero behaves as one
    if (cnt_q == '0)
      cur_len = (bus.acc_len == '0) ? LEN_WIDTH'(1) : bus.acc_len;
    else
      cur_len = len_q;

    sum_i_d    = sum_i_q;
    sum_q_d    = sum_q_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    dump_i_d   = dump_i_q;
    dump_q_d   = dump_q_q;
    dump_vld_d = 1'b0;
    ovf_d      = ovf_q;

    if (!vld_pipe_q[1]) begin
      sum_i_d = '0;
      sum_q_d = '0;
      cnt_d   = '0;
    end else begin
      len_d = cur_len;
      if (ovf_i || ovf_q_ch) ovf_d = 1'b1;
      if (cnt_q == cur_len - LEN_WIDTH'(1)) begin
        dump_i_d   = add_i;
        dump_q_d   = add_q;
        dump_vld_d = 1'b1;
        sum_i_d    = '0;
        sum_q_d    = '0;
        cnt_d      = '0;
      end else begin
        sum_i_d = add_i;
        sum_q_d = add_q;
        cnt_d   = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  // Output register: last sample at edge E shows valid after edge E+3
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    valid_d = dump_vld_q;
    if (dump_vld_q) begin
      acc_i_d = dump_i_q;
      acc_q_d = dump_q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      vld_pipe_q <= '0;
      p_ic_q     <= '0;
      p_qs_q     <= '0;
      p_qc_q     <= '0;
      p_is_q     <= '0;
      mi_q       <= '0;
      mq_q       <= '0;
      sum_i_q    <= '0;
      sum_q_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      dump_i_q   <= '0;
      dump_q_q   <= '0;
      dump_vld_q <= 1'b0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      p_ic_q     <= p_ic_d;
      p_qs_q     <= p_qs_d;
      p_qc_q     <= p_qc_d;
      p_is_q     <= p_is_d;
      mi_q       <= mi_d;
      mq_q       <= mq_d;
      sum_i_q    <= sum_i_d;
      sum_q_q    <= sum_q_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      dump_i_q   <= dump_i_d;
      dump_q_q   <= dump_q_d;
      dump_vld_q <= dump_vld_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.acc_i    = acc_i_q;
  assign bus.acc_q    = acc_q_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_carrier_wipeoff_accum.sv
// Directed scoreboard bench: stimulus pushes expected dumps (value and cycle), a negedge
// monitor pops on every valid pulse. A second instance with 8-bit sums exercises wrap.
module tb_carrier_wipeoff_accum;
  logic clk = 1'b0;
  logic syn_reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carrier_wipeoff_accum_if #(.IN_WIDTH(3), .OUT_WIDTH(24), .LEN_WIDTH(16)) ifc ();
  carrier_wipeoff_accum_if #(.IN_WIDTH(3), .OUT_WIDTH(8),  .LEN_WIDTH(16)) ifc8 ();

  carrier_wipeoff_accum #(.IN_WIDTH(3), .OUT_WIDTH(24), .LEN_WIDTH(16)) dut (
    .clk(clk), .syn_reset(syn_reset), .bus(ifc.slave));
  carrier_wipeoff_accum #(.IN_WIDTH(3), .OUT_WIDTH(8), .LEN_WIDTH(16)) dut8 (
    .clk(clk), .syn_reset(syn_reset), .bus(ifc8.slave));

  typedef struct {int i; int q; int cyc;} exp_t;
  exp_t sb[$];
  exp_t sb8[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifc.valid) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_valid: got valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("acc_i", int'(ifc.acc_i), e.i);
        check("acc_q", int'(ifc.acc_q), e.q);
        check("valid_cycle", cyc, e.cyc);
      end
    end
    if (ifc8.valid) begin
      if (sb8.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_valid8: got valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb8.pop_front();
        check("acc_i8", int'(ifc8.acc_i), e.i);
        check("acc_q8", int'(ifc8.acc_q), e.q);
        check("valid_cycle8", cyc, e.cyc);
      end
    end
  end

  // drive one sample, return just after the edge that captured it (cyc == capture edge)
  task automatic samp(input logic e, input int i, input int q, input int s, input int c);
    ifc.en = e; ifc.in_i = i[2:0]; ifc.in_q = q[2:0]; ifc.sin = s[2:0]; ifc.cos = c[2:0];
    @(posedge clk); #1;
  endtask

  task automatic samp8(input logic e, input int i, input int q, input int s, input int c);
    ifc8.en = e; ifc8.in_i = i[2:0]; ifc8.in_q = q[2:0]; ifc8.sin = s[2:0]; ifc8.cos = c[2:0];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ifc8.en = 1'b0;
      samp(1'b0, 0, 0, 0, 0);
    end
  endtask

  task automatic push(input int i, input int q);
    sb.push_back('{i, q, cyc + 3});
  endtask

  initial begin
    ifc.en = 0; ifc.in_i = 0; ifc.in_q = 0; ifc.sin = 0; ifc.cos = 0; ifc.acc_len = 16'd4;
    ifc8.en = 0; ifc8.in_i = 0; ifc8.in_q = 0; ifc8.sin = 0; ifc8.cos = 0; ifc8.acc_len = 16'd20;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_i", int'(ifc.acc_i), 0);
    check("rst_acc_q", int'(ifc.acc_q), 0);
    check("rst_valid", int'(ifc.valid), 0);
    check("rst_overflow", int'(ifc.overflow), 0);
    syn_reset = 1'b0;
    idle(2);

    // 1: window of 4, mi = 1*3 = 3 -> 12
    ifc.acc_len = 16'd4;
    repeat (4) samp(1'b1, 1, 0, 0, 3);
    push(12, 0);
    idle(6);

    // 2: window of 2, mi = 2*3 = 6 -> three dumps of 12 back to back
    ifc.acc_len = 16'd2;
    for (int k = 1; k <= 6; k++) begin
      samp(1'b1, 0, 2, 3, 0);
      if (k % 2 == 0) push(12, 0);
    end
    idle(6);

    // 3: partial window aborted by a one-cycle en gap
    ifc.acc_len = 16'd4;
    repeat (3) samp(1'b1, 1, 0, 0, 3);
    samp(1'b0, 1, 0, 0, 3);
    repeat (4) samp(1'b1, 1, 0, 0, 3);
    push(12, 0);
    idle(6);

    // 3b: gap lands exactly on what would be the last sample
    repeat (3) samp(1'b1, 1, 0, 0, 3);
    samp(1'b0, 1, 0, 0, 3);
    idle(6);

    // 4: length 0 acts as 1; mi = 2+1 = 3, mq = -1+2 = 1 every cycle
    ifc.acc_len = 16'd0;
    repeat (3) begin
      samp(1'b1, -2, 1, 1, -1);
      push(3, 1);
    end
    idle(6);
    check("hold_acc_i", int'(ifc.acc_i), 3);
    check("hold_acc_q", int'(ifc.acc_q), 1);
    check("overflow24", int'(ifc.overflow), 0);

    // 5: 8-bit sums, 20 x 9 = 180 wraps to -76, overflow sticks
    ifc8.acc_len = 16'd20;
    repeat (20) samp8(1'b1, 3, 0, 0, 3);
    sb8.push_back('{-76, 0, cyc + 3});
    idle(6);
    check("overflow8_set", int'(ifc8.overflow), 1);
    idle(5);
    check("overflow8_sticky", int'(ifc8.overflow), 1);

    // 6: reset mid-window, then a clean window
    ifc.acc_len = 16'd4;
    repeat (2) samp(1'b1, 1, 0, 0, 3);
    syn_reset = 1'b1;
    idle(2);
    check("midrst_acc_i", int'(ifc.acc_i), 0);
    check("midrst_acc_q", int'(ifc.acc_q), 0);
    check("midrst_valid", int'(ifc.valid), 0);
    check("midrst_overflow8", int'(ifc8.overflow), 0);
    syn_reset = 1'b0;
    repeat (4) samp(1'b1, 1, 0, 0, 3);
    push(12, 0);
    idle(6);

    check("sb_remaining", sb.size(), 0);
    check("sb8_remaining", sb8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
